// File: rtl/pc_sequencer.sv
// Program-counter sequencer with an integrated return stack, stall, and stack-fault trapping.
// Define PC_SEQ_RELATIVE_BRANCH_EN to enable the BRANCH/IF0BRANCH relative opcodes.
module pc_sequencer #(
  parameter int PC_WIDTH       = 8,
  parameter int VALUE_WIDTH    = 8,
  parameter int REGISTER_WIDTH = 8,
  parameter int OPCODE_WIDTH   = 4,
  parameter int STACK_DEPTH    = 16,
  parameter int RESET_VECTOR   = 0,
  parameter int TRAP_VECTOR    = 'hF0,
  localparam int CNT_W         = $clog2(STACK_DEPTH + 1)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      stall,
  input  logic [OPCODE_WIDTH-1:0]   resetCode,
  input  logic [VALUE_WIDTH-1:0]    instructionValue,
  input  logic [REGISTER_WIDTH-1:0] registerValue,
  output logic [PC_WIDTH-1:0]       pc,
  output logic [PC_WIDTH-1:0]       returnAddress,
  output logic [CNT_W-1:0]          stackCount,
  output logic                      stackOverflow,
  output logic                      stackUnderflow
);

  localparam int IDX_W = $clog2(STACK_DEPTH);
  // One spare bit guarantees a non-empty extension field for any width combination.
  localparam int EXT_W = ((PC_WIDTH > VALUE_WIDTH) ? PC_WIDTH : VALUE_WIDTH) + 1;

  localparam logic [OPCODE_WIDTH-1:0] OP_NOP     = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_JUMP    = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_IF0JUMP = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_IF1JUMP = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_CALL    = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_RET     = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_RESET   = OPCODE_WIDTH'(6);
`ifdef PC_SEQ_RELATIVE_BRANCH_EN
  localparam logic [OPCODE_WIDTH-1:0] OP_BRANCH    = OPCODE_WIDTH'(7);
  localparam logic [OPCODE_WIDTH-1:0] OP_IF0BRANCH = OPCODE_WIDTH'(8);
`endif

  localparam logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(RESET_VECTOR);
  localparam logic [PC_WIDTH-1:0] TRAP_PC  = PC_WIDTH'(TRAP_VECTOR);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];

  logic                push_s;
  logic                full_s, empty_s;
  logic [IDX_W-1:0]    top_idx_s, push_idx_s;
  logic [PC_WIDTH-1:0] pc_plus_one_s, target_s, top_s;
  logic [EXT_W-1:0]    zext_s;

  assign zext_s        = {{(EXT_W-VALUE_WIDTH){1'b0}}, instructionValue};
  assign target_s      = zext_s[PC_WIDTH-1:0];
  assign pc_plus_one_s = pc_q + PC_WIDTH'(1);
  assign full_s        = (count_q == CNT_W'(STACK_DEPTH));
  assign empty_s       = (count_q == {CNT_W{1'b0}});
  assign top_idx_s     = IDX_W'(count_q - CNT_W'(1));
  assign push_idx_s    = IDX_W'(count_q);
  assign top_s         = empty_s ? {PC_WIDTH{1'b0}} : stack_q[top_idx_s];

`ifdef PC_SEQ_RELATIVE_BRANCH_EN
  logic [EXT_W-1:0]    sext_s;
  logic [PC_WIDTH-1:0] rel_target_s;
  assign sext_s       = {{(EXT_W-VALUE_WIDTH){instructionValue[VALUE_WIDTH-1]}}, instructionValue};
  assign rel_target_s = pc_q + sext_s[PC_WIDTH-1:0];
`endif

  // Next-state decode; the reset port is folded in so it also suppresses any push.
  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push_s  = 1'b0;
    if (reset) begin
      pc_d    = RESET_PC;
      count_d = {CNT_W{1'b0}};
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else if (stall) begin
      pc_d = pc_q;
    end else begin
      case (resetCode)
        OP_NOP:     pc_d = pc_plus_one_s;
        OP_JUMP:    pc_d = target_s;
        OP_IF0JUMP: pc_d = (registerValue == '0) ? target_s : pc_plus_one_s;
        OP_IF1JUMP: pc_d = (registerValue != '0) ? target_s : pc_plus_one_s;
        OP_CALL: begin
          if (full_s) begin
            ovf_d = 1'b1;
            pc_d  = TRAP_PC;
          end else begin
            push_s  = 1'b1;
            count_d = count_q + CNT_W'(1);
            pc_d    = target_s;
          end
        end
        OP_RET: begin
          if (empty_s) begin
            unf_d = 1'b1;
            pc_d  = TRAP_PC;
          end else begin
            count_d = count_q - CNT_W'(1);
            pc_d    = top_s;
          end
        end
        OP_RESET: begin
          pc_d    = RESET_PC;
          count_d = {CNT_W{1'b0}};
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
        end
`ifdef PC_SEQ_RELATIVE_BRANCH_EN
        OP_BRANCH:    pc_d = rel_target_s;
        OP_IF0BRANCH: pc_d = (registerValue == '0) ? rel_target_s : pc_plus_one_s;
`endif
        default:    pc_d = pc_plus_one_s;
      endcase
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      count_q <= {CNT_W{1'b0}};
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack storage is deliberately not reset; only the occupancy count is.
  always_ff @(posedge clock) begin
    if (push_s) begin
      stack_q[push_idx_s] <= pc_plus_one_s;
    end
  end

  assign pc             = pc_q;
  assign returnAddress  = top_s;
  assign stackCount     = count_q;
  assign stackOverflow  = ovf_q;
  assign stackUnderflow = unf_q;

endmodule
